seg7_scroller: RTL and testbench

Sequential driver for the board's single 7-segment display (`SEG`). It latches an `NDIGITS`-digit hexadecimal value and shows the digits one at a time, most significant digit first, on `SEG`. Each digit is held for a programmable number of clock cycles and is followed by a blank gap of the same length, so repeated digits stay distinguishable. It instantiates alongside the student logic in `top`, driven from `SWI`, and generalises the fixed single-digit combinational `SEG` drive into a parametrised multi-digit, looping display.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_scroller_if.sv | 36 +++
 rtl/hex_to_seg7.sv | 16 +
 rtl/seg7_scroller.sv | 155 +++++++++++++++
 tb/tb_seg7_scroller.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scroller:
//   state_t  - scroller FSM states (IDLE, SHOW, GAP)
//   HEX_SEG7 - hex digit to segment pattern table, bit order g..a (bit 0 = a)
//   DP_BIT   - bit position of the decimal point in the SEG bus
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Index 0 is the first element, so the table reads 0..F left to right.
  localparam logic [6:0] HEX_SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int DP_BIT = 7;

endpackage

// File: rtl/seg7_scroller_if.sv
// -----------------------------------------------------------------------------
// seg7_scroller_if
// Bundles the request and display signals of seg7_scroller.
//   load      - one-cycle request to capture data and (re)start the sequence
//   data      - NDIGITS hex digits, digit k in bits [4k+3:4k]
//   en        - clock enable for the whole scroller
//   loop      - repeat the sequence when it ends
//   SEG       - registered segment pattern (bits 0-6 = a-g, bit 7 = dp)
//   busy      - high whenever the scroller is not idle
//   digit_idx - digit currently shown or last shown
// Modports: master drives the request side, slave is the scroller itself.
// -----------------------------------------------------------------------------
interface seg7_scroller_if #(
  parameter int NDIGITS   = 4,
  parameter int NBITS_SEG = 8
);

  logic                         load;
  logic [4*NDIGITS-1:0]         data;
  logic                         en;
  logic                         loop;
  logic [NBITS_SEG-1:0]         SEG;
  logic                         busy;
  logic [$clog2(NDIGITS)-1:0]   digit_idx;

  modport master (
    output load, data, en, loop,
    input  SEG, busy, digit_idx
  );

  modport slave (
    input  load, data, en, loop,
    output SEG, busy, digit_idx
  );

endinterface

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex digit to 7-segment decoder using the package table.
//   hex - 4-bit digit value
//   seg - segment pattern, bit 0 = a ... bit 6 = g, active high
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG7[hex];

endmodule

// File: rtl/seg7_scroller.sv
// -----------------------------------------------------------------------------
// seg7_scroller
// Shows an NDIGITS-digit hex value on a single 7-segment display, one digit at
// a time, most significant first. Each digit is shown for TICK_DIV enabled
// cycles and followed by a blank gap of the same length. The decimal point
// marks digit 0. With loop high at the end of the sequence it starts over.
//
// Ports:
//   clk_2 - clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - seg7_scroller_if.slave (load/data/en/loop in, SEG/busy/digit_idx out)
//
// Build option SEG7_SCROLLER_LEADZERO_BLANK_EN: when defined, the sequence
// starts at the highest nonzero digit so leading zeros are skipped entirely;
// an all-zero value shows only digit 0. When undefined every sequence starts
// at digit NDIGITS-1.
// -----------------------------------------------------------------------------
module seg7_scroller
  import seg7_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int TICK_DIV  = 2,
  parameter int NBITS_SEG = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  seg7_scroller_if.slave   bus
);

  localparam int IDX_W = $clog2(NDIGITS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICK_DIV - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [NBITS_SEG-1:0]   seg_q, seg_d;

  logic [IDX_W-1:0]       start_load;   // start digit for a fresh load
  logic [IDX_W-1:0]       start_loop;   // start digit for a loop restart
  logic [3:0]             digit_d;
  logic [6:0]             segs_d;

`ifdef SEG7_SCROLLER_LEADZERO_BLANK_EN
  // Highest nonzero digit, or digit 0 when the whole value is zero.
  function automatic logic [IDX_W-1:0] top_digit(input logic [4*NDIGITS-1:0] value);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (value[4*k +: 4] != 4'h0) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  assign start_load = top_digit(bus.data);
  assign start_loop = top_digit(shadow_q);
`else
  assign start_load = LAST_IDX;
  assign start_loop = LAST_IDX;
`endif

  // Next-state logic. Everything holds while en is low, including load.
  // load takes priority over any phase or sequence end in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;

    if (bus.en) begin
      if (bus.load) begin
        shadow_d = bus.data;
        state_d  = SHOW;
        idx_d    = start_load;
        cnt_d    = '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          SHOW: begin
            if (cnt_q == LAST_TICK) begin
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          GAP: begin
            if (cnt_q == LAST_TICK) begin
              cnt_d = '0;
              if (idx_q != '0) begin
                state_d = SHOW;
                idx_d   = idx_q - 1'b1;
              end else if (bus.loop) begin
                state_d = SHOW;
                idx_d   = start_loop;
              end else begin
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // SEG is decoded from the next state so the pattern changes on the same
  // edge as the state, giving each phase exactly TICK_DIV cycles on the pins.
  assign digit_d = shadow_d[4*idx_d +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit_d),
    .seg (segs_d)
  );

  always_comb begin
    seg_d = '0;
    if (state_d == SHOW) begin
      seg_d[6:0]    = segs_d;
      seg_d[DP_BIT] = (idx_d == '0);
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow register is reset too, so no state ever carries X
      // into the decoder before the first load.
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.SEG       = seg_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scroller.sv
// -----------------------------------------------------------------------------
// tb_seg7_scroller
// Self-checking bench for seg7_scroller with NDIGITS=4, TICK_DIV=2.
// Expected per-cycle {SEG, busy, digit_idx} tuples are pushed to a queue when
// a sequence is started and popped one per clock as the DUT runs.
// -----------------------------------------------------------------------------
module tb_seg7_scroller;

  localparam int ND = 4;
  localparam int TD = 2;

  logic clk;
  logic rst;

  seg7_scroller_if #(.NDIGITS(ND), .NBITS_SEG(8)) bus ();

  seg7_scroller #(
    .NDIGITS   (ND),
    .TICK_DIV  (TD),
    .NBITS_SEG (8)
  ) dut (
    .clk_2 (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic       busy;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ref_code(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected tuples of one full pass from digit 'start' down to digit 0.
  task automatic push_seq(input logic [15:0] v, input int start);
    logic [3:0] h;
    logic [7:0] s;
    for (int k = start; k >= 0; k--) begin
      h = v[4*k +: 4];
      s = {(k == 0), ref_code(h)};
      repeat (TD) sb.push_back('{seg: s, busy: 1'b1, idx: 2'(k)});
      repeat (TD) sb.push_back('{seg: 8'h00, busy: 1'b1, idx: 2'(k)});
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) sb.push_back('{seg: 8'h00, busy: 1'b0, idx: 2'd0});
  endtask

  // Compare up to n queued tuples, one per clock.
  task automatic drain_n(input string name, input int n);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      e   = sb.pop_front();
      got = {bus.SEG, bus.busy, bus.digit_idx};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s[%0d]: got seg=%h busy=%b idx=%0d, want seg=%h busy=%b idx=%0d",
                 name, i, got.seg, got.busy, got.idx, e.seg, e.busy, e.idx);
      end
      step();
    end
  endtask

  task automatic drain(input string name);
    drain_n(name, sb.size());
  endtask

  task automatic start_load(input logic [15:0] v);
    bus.data = v;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    bus.en   = 1'b1;
    bus.loop = 1'b0;
    step();
    step();
    total++;
    if (bus.SEG !== 8'h00) begin
      bad++; $display("FAIL reset_seg: got %h want 00", bus.SEG);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    total++;
    if (bus.digit_idx !== 2'd0) begin
      bad++; $display("FAIL reset_idx: got %0d want 0", bus.digit_idx);
    end
    rst = 1'b0;
    step();
    step();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_release_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_oneshot();
    bus.loop = 1'b0;
    start_load(16'h1A3F);
    push_seq(16'h1A3F, 3);
    push_idle(2);
    drain("oneshot");
  endtask

  task automatic test_loop();
    bus.loop = 1'b1;
    start_load(16'h1A3F);
    push_seq(16'h1A3F, 3);
    push_seq(16'h1A3F, 3);
    drain("loop");
    // Third pass is already running; dropping loop ends it after this pass.
    bus.loop = 1'b0;
    push_seq(16'h1A3F, 3);
    push_idle(2);
    drain("loop_stop");
  endtask

  task automatic test_reload();
    start_load(16'h1A3F);
    push_seq(16'h1A3F, 3);
    drain_n("reload_pre", 5);
    sb.delete();
    start_load(16'h2222);
    push_seq(16'h2222, 3);
    push_idle(2);
    drain("reload");
  endtask

  task automatic test_enable_freeze();
    logic [11:0] got;
    start_load(16'h1A3F);
    push_seq(16'h1A3F, 3);
    push_idle(2);
    drain_n("freeze_pre", 1);
    // Frozen mid-SHOW; a load during the freeze must be ignored.
    bus.en   = 1'b0;
    bus.data = 16'h2222;
    bus.load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      got = {bus.SEG, bus.busy, 1'b0, bus.digit_idx};
      total++;
      if (got !== {8'h06, 1'b1, 1'b0, 2'd3}) begin
        bad++;
        $display("FAIL freeze[%0d]: got seg=%h busy=%b idx=%0d, want seg=06 busy=1 idx=3",
                 i, bus.SEG, bus.busy, bus.digit_idx);
      end
      step();
    end
    bus.load = 1'b0;
    bus.data = 16'h1A3F;
    bus.en   = 1'b1;
    drain("freeze_resume");
  endtask

  task automatic test_reset_mid();
    start_load(16'h1A3F);
    push_seq(16'h1A3F, 3);
    drain_n("rstmid_pre", 4);
    sb.delete();
    total++;
    if (bus.SEG !== 8'h77) begin
      bad++; $display("FAIL rstmid_showA: got %h want 77", bus.SEG);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.SEG !== 8'h00) begin
      bad++; $display("FAIL rstmid_seg: got %h want 00", bus.SEG);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy);
    end
    total++;
    if (bus.digit_idx !== 2'd0) begin
      bad++; $display("FAIL rstmid_idx: got %0d want 0", bus.digit_idx);
    end
    step();
    step();
    rst = 1'b0;
    step();
    push_idle(4);
    drain("rstmid_idle");
  endtask

`ifdef SEG7_SCROLLER_LEADZERO_BLANK_EN
  task automatic test_leadzero();
    start_load(16'h0005);
    push_seq(16'h0005, 0);
    push_idle(2);
    drain("lz_0005");
    start_load(16'h0000);
    push_seq(16'h0000, 0);
    push_idle(2);
    drain("lz_0000");
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_oneshot();
    test_loop();
    test_reload();
    test_enable_freeze();
    test_reset_mid();
`ifdef SEG7_SCROLLER_LEADZERO_BLANK_EN
    test_leadzero();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
